// File: rtl/adc_code_decimator.sv
// Frame decimator for ADC codes: sums 2^LOG2_N samples and reports sum, mean,
// clip count and optionally min/max (build with ADC_DECIM_MINMAX_EN).
module adc_code_decimator #(
    parameter int B      = 8,
    parameter int LOG2_N = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [B-1:0]        in_code,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [B+LOG2_N-1:0] out_sum,
    output logic [B-1:0]        out_mean,
    output logic [LOG2_N:0]     out_clip,
    output logic [B-1:0]        out_min,
    output logic [B-1:0]        out_max,
    output logic                overrun
);

    localparam int SW = B + LOG2_N;
    localparam int CW = LOG2_N + 1;

    logic [LOG2_N-1:0] cntQ, cntD;
    logic [SW-1:0]     accQ, accD, accNext;
    logic [CW-1:0]     clipQ, clipD, clipNext;
    logic              outValidQ, outValidD;
    logic [SW-1:0]     outSumQ, outSumD;
    logic [CW-1:0]     outClipQ, outClipD;
    logic              overrunQ, overrunD;

    logic isFirst, isLast, isClip, frameDone, transfer, canLoad;

    assign isFirst   = (cntQ == '0);
    assign isLast    = (cntQ == '1);
    assign isClip    = (in_code == {B{1'b1}});
    assign frameDone = in_valid & isLast;
    assign transfer  = outValidQ & out_ready;
    assign canLoad   = ~outValidQ | out_ready;

    // The first sample of a frame seeds the running values instead of combining.
    assign accNext  = (isFirst ? '0 : accQ) + {{LOG2_N{1'b0}}, in_code};
    assign clipNext = (isFirst ? '0 : clipQ) + {{LOG2_N{1'b0}}, isClip};

    always_comb begin
        cntD      = cntQ;
        accD      = accQ;
        clipD     = clipQ;
        outValidD = outValidQ;
        outSumD   = outSumQ;
        outClipD  = outClipQ;
        overrunD  = overrunQ;
        if (clear) begin
            cntD      = '0;
            accD      = '0;
            clipD     = '0;
            outValidD = 1'b0;
            outSumD   = '0;
            outClipD  = '0;
            overrunD  = 1'b0;
        end else begin
            if (in_valid) begin
                cntD  = cntQ + 1'b1;
                accD  = accNext;
                clipD = clipNext;
            end
            if (transfer) begin
                outValidD = 1'b0;
            end
            // A completed frame wins over the transfer; if the holder stays full it is dropped.
            if (frameDone) begin
                if (canLoad) begin
                    outValidD = 1'b1;
                    outSumD   = accNext;
                    outClipD  = clipNext;
                end else begin
                    overrunD = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cntQ      <= '0;
            accQ      <= '0;
            clipQ     <= '0;
            outValidQ <= 1'b0;
            outSumQ   <= '0;
            outClipQ  <= '0;
            overrunQ  <= 1'b0;
        end else begin
            cntQ      <= cntD;
            accQ      <= accD;
            clipQ     <= clipD;
            outValidQ <= outValidD;
            outSumQ   <= outSumD;
            outClipQ  <= outClipD;
            overrunQ  <= overrunD;
        end
    end

    assign out_valid = outValidQ;
    assign out_sum   = outSumQ;
    assign out_mean  = outSumQ[SW-1:LOG2_N];
    assign out_clip  = outClipQ;
    assign overrun   = overrunQ;

`ifdef ADC_DECIM_MINMAX_EN
    logic [B-1:0] minQ, minD, maxQ, maxD, minNext, maxNext;
    logic [B-1:0] outMinQ, outMinD, outMaxQ, outMaxD;
    logic         frameLoad;

    assign frameLoad = frameDone & canLoad & ~clear;
    assign minNext   = (isFirst || (in_code < minQ)) ? in_code : minQ;
    assign maxNext   = (isFirst || (in_code > maxQ)) ? in_code : maxQ;

    // Trackers follow the same clear/load rules as the sum and clip paths.
    always_comb begin
        minD    = minQ;
        maxD    = maxQ;
        outMinD = outMinQ;
        outMaxD = outMaxQ;
        if (clear) begin
            minD    = '0;
            maxD    = '0;
            outMinD = '0;
            outMaxD = '0;
        end else begin
            if (in_valid) begin
                minD = minNext;
                maxD = maxNext;
            end
            if (frameLoad) begin
                outMinD = minNext;
                outMaxD = maxNext;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            minQ    <= '0;
            maxQ    <= '0;
            outMinQ <= '0;
            outMaxQ <= '0;
        end else begin
            minQ    <= minD;
            maxQ    <= maxD;
            outMinQ <= outMinD;
            outMaxQ <= outMaxD;
        end
    end

    assign out_min = outMinQ;
    assign out_max = outMaxQ;
`else
    assign out_min = '0;
    assign out_max = '0;
`endif

endmodule

// File: tb/tb_adc_code_decimator.sv
// Scoreboard bench for adc_code_decimator with B=8, LOG2_N=2 (4-sample frames).
module tb_adc_code_decimator;

    localparam int B      = 8;
    localparam int LOG2_N = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                clear = 1'b0;
    logic                in_valid = 1'b0;
    logic [B-1:0]        in_code = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [B+LOG2_N-1:0] out_sum;
    logic [B-1:0]        out_mean;
    logic [LOG2_N:0]     out_clip;
    logic [B-1:0]        out_min;
    logic [B-1:0]        out_max;
    logic                overrun;

    typedef struct {
        int sum;
        int mean;
        int clip;
        int mn;
        int mx;
    } frame_t;

    frame_t sb[$];
    int total = 0;
    int bad = 0;

    adc_code_decimator #(.B(B), .LOG2_N(LOG2_N)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_mean(out_mean), .out_clip(out_clip),
        .out_min(out_min), .out_max(out_max), .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pushes hand-computed frame results; min/max are 0 when trackers are not built.
    task automatic expectFrame(input int s, input int m, input int c, input int mn, input int mx);
        frame_t f;
        f.sum  = s;
        f.mean = m;
        f.clip = c;
`ifdef ADC_DECIM_MINMAX_EN
        f.mn = mn;
        f.mx = mx;
`else
        f.mn = 0;
        f.mx = 0;
        if (mn + mx < 0) f.mn = 0;
`endif
        sb.push_back(f);
    endtask

    // Called at posedge+1; presents one sample for one clock.
    task automatic applyStimulus(input int code);
        in_valid = 1'b1;
        in_code  = B'(code);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_sum"}, int'(out_sum), 0);
        checkOutput({tag, "_mean"}, int'(out_mean), 0);
        checkOutput({tag, "_clip"}, int'(out_clip), 0);
        checkOutput({tag, "_min"}, int'(out_min), 0);
        checkOutput({tag, "_max"}, int'(out_max), 0);
        checkOutput({tag, "_overrun"}, int'(overrun), 0);
    endtask

    // Monitor: a transfer happens on the next edge whenever valid&ready is seen here.
    initial begin
        frame_t f;
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", 1, 0);
                end else begin
                    f = sb.pop_front();
                    checkOutput("sb_sum", int'(out_sum), f.sum);
                    checkOutput("sb_mean", int'(out_mean), f.mean);
                    checkOutput("sb_clip", int'(out_clip), f.clip);
                    checkOutput("sb_min", int'(out_min), f.mn);
                    checkOutput("sb_max", int'(out_max), f.mx);
                end
            end
        end
    end

    initial begin
        #12;
        checkAllZero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Contiguous frame
        expectFrame(100, 25, 0, 10, 40);
        applyStimulus(10); applyStimulus(20); applyStimulus(30); applyStimulus(40);
        checkOutput("contig_latency", int'(out_valid), 1);
        idle(1);
        checkOutput("contig_pulse_end", int'(out_valid), 0);

        // Full-scale frame
        expectFrame(1020, 255, 4, 255, 255);
        for (int i = 0; i < 4; i++) applyStimulus(255);
        checkOutput("fullscale_latency", int'(out_valid), 1);
        idle(1);

        // Gapped input
        expectFrame(10, 2, 0, 1, 4);
        applyStimulus(1); applyStimulus(2); idle(2);
        applyStimulus(3); idle(3); applyStimulus(4);
        checkOutput("gapped_latency", int'(out_valid), 1);
        idle(1);
        checkOutput("gapped_pulse_end", int'(out_valid), 0);

        // Backpressure: A held, B dropped
        out_ready = 1'b0;
        expectFrame(20, 5, 0, 5, 5);
        for (int i = 0; i < 4; i++) applyStimulus(5);
        checkOutput("bp_overrun_before", int'(overrun), 0);
        for (int i = 0; i < 4; i++) applyStimulus(7);
        idle(2);
        checkOutput("bp_held_valid", int'(out_valid), 1);
        checkOutput("bp_held_sum", int'(out_sum), 20);
        checkOutput("bp_overrun", int'(overrun), 1);
        out_ready = 1'b1;
        idle(1);
        checkOutput("bp_valid_fall", int'(out_valid), 0);
        checkOutput("bp_overrun_sticky", int'(overrun), 1);
        idle(2);
        checkOutput("bp_overrun_still", int'(overrun), 1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        checkOutput("bp_overrun_cleared", int'(overrun), 0);

        // Simultaneous transfer of A and load of B
        out_ready = 1'b0;
        expectFrame(20, 5, 0, 5, 5);
        for (int i = 0; i < 4; i++) applyStimulus(5);
        expectFrame(28, 7, 0, 7, 7);
        for (int i = 0; i < 3; i++) applyStimulus(7);
        out_ready = 1'b1;
        applyStimulus(7);
        checkOutput("sim_valid_stays", int'(out_valid), 1);
        checkOutput("sim_sum_b", int'(out_sum), 28);
        checkOutput("sim_overrun", int'(overrun), 0);
        idle(1);

        // Asynchronous reset mid-frame
        applyStimulus(11); applyStimulus(12);
        reset = 1'b1;
        #2;
        checkAllZero("midreset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        expectFrame(36, 9, 0, 9, 9);
        for (int i = 0; i < 4; i++) applyStimulus(9);
        idle(1);

        // Clear mid-frame, with a coincident sample that must be discarded
        applyStimulus(3); applyStimulus(3);
        clear = 1'b1;
        applyStimulus(50);
        clear = 1'b0;
        checkAllZero("midclear");
        expectFrame(36, 9, 0, 9, 9);
        for (int i = 0; i < 4; i++) applyStimulus(9);
        checkOutput("clear_latency", int'(out_valid), 1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        checkOutput("scoreboard_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
